// File: rtl/mem_stage_pkg.sv
// Shared RV32I memory-stage types: load/store width codes, stage FSM states,
// byte-mask constants and the width decode used by both store and load paths.
package mem_stage_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        HOLD
    } memstage_state_t;

    typedef enum logic [1:0] {
        W_BYTE,
        W_HALF,
        W_WORD
    } access_width_t;

    localparam logic [3:0] MBE_BYTE = 4'b0001;
    localparam logic [3:0] MBE_HALF = 4'b0011;
    localparam logic [3:0] MBE_WORD = 4'b1111;

    // Unsigned load codes are not legal store codes, so those fall back to word.
    function automatic access_width_t decode_width(input logic [2:0] f3, input logic is_store);
        access_width_t w;
        case (f3)
            3'b000:  w = W_BYTE;
            3'b001:  w = W_HALF;
            3'b100:  w = is_store ? W_WORD : W_BYTE;
            3'b101:  w = is_store ? W_WORD : W_HALF;
            default: w = W_WORD;
        endcase
        return w;
    endfunction

    function automatic logic is_misaligned(input access_width_t w, input logic [1:0] off);
        logic m;
        case (w)
            W_HALF:  m = off[0];
            W_WORD:  m = |off;
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_stage_load_formatter.sv
// Combinational load alignment: picks the byte/half addressed by off out of the
// cache word and sign- or zero-extends it according to funct3.
module load_formatter
    import mem_stage_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    output logic [31:0] load_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign sel_byte = word[{off, 3'b000} +: 8];
    assign sel_half = off[1] ? word[31:16] : word[15:0];

    always_comb begin
        load_data = word;
        case (funct3)
            3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
            3'b100:  load_data = {24'b0, sel_byte};
            3'b101:  load_data = {16'b0, sel_half};
            default: load_data = word;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: D-cache handshake, store lane shaping, load alignment and
// pipeline stall. Optional misalignment trap enabled by MEM_MISALIGN_CHECK_EN.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_valid_in,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr_in,
    input  logic [XLEN-1:0] store_data,
    input  logic            ext_stall,
    input  logic            data_resp,
    input  logic [XLEN-1:0] data_rdata,
    output logic            data_read,
    output logic            data_write,
    output logic [3:0]      data_mbe,
    output logic [XLEN-1:0] data_addr,
    output logic [XLEN-1:0] data_wdata,
    output logic [XLEN-1:0] load_data,
    output logic            mem_stall,
    output logic            mem_timeout
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    output logic            misaligned_o
`endif
);

    localparam logic [31:0] MAX_WAIT_U = 32'(MAX_WAIT);

    memstage_state_t state, state_nxt;
    logic [XLEN-1:0] data_buf;
    logic [31:0]     wait_cnt, wait_inc;

    logic            is_load, is_store, mis, req;
    logic [1:0]      off;
    access_width_t   width;
    logic            rd, wr, stall, capture;
    logic [3:0]      mbe_raw;
    logic [XLEN-1:0] wdata_raw, load_word, load_fmt;

    // A read+write collision is resolved as a load.
    assign is_load  = mem_read;
    assign is_store = mem_write & ~mem_read;
    assign off      = addr_in[1:0];
    assign width    = decode_width(funct3, is_store);

`ifdef MEM_MISALIGN_CHECK_EN
    assign mis = mem_valid_in & (mem_read | mem_write) & is_misaligned(width, off);
`else
    assign mis = 1'b0;
`endif

    assign req = mem_valid_in & (mem_read | mem_write) & ~mis;

    always_comb begin
        state_nxt = state;
        rd        = 1'b0;
        wr        = 1'b0;
        stall     = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    rd = is_load;
                    wr = is_store;
                    if (data_resp) begin
                        capture   = 1'b1;
                        state_nxt = ext_stall ? HOLD : IDLE;
                    end else begin
                        stall     = 1'b1;
                        state_nxt = BUSY;
                    end
                end
            end
            // EX/MEM is frozen by our stall, so the inputs still describe the same access.
            BUSY: begin
                rd = is_load;
                wr = is_store;
                if (data_resp) begin
                    capture   = 1'b1;
                    state_nxt = ext_stall ? HOLD : IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            HOLD: begin
                if (!ext_stall) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mbe_raw   = MBE_WORD;
        wdata_raw = store_data;
        case (width)
            W_BYTE: begin
                mbe_raw   = MBE_BYTE << off;
                wdata_raw = {4{store_data[7:0]}};
            end
            // Offset 3 lands on the upper half; the byte past the word is dropped.
            W_HALF: begin
                mbe_raw   = MBE_HALF << {off[1], 1'b0};
                wdata_raw = {2{store_data[15:0]}};
            end
            default: begin
                mbe_raw   = MBE_WORD;
                wdata_raw = store_data;
            end
        endcase
    end

    assign load_word = data_resp ? data_rdata : data_buf;

    load_formatter u_load_formatter (
        .word      (load_word),
        .funct3    (funct3),
        .off       (off),
        .load_data (load_fmt)
    );

    assign data_read  = ~rst & rd;
    assign data_write = ~rst & wr;
    assign data_mbe   = data_write ? mbe_raw : 4'b0000;
    assign data_addr  = rst ? '0 : {addr_in[XLEN-1:2], 2'b00};
    assign data_wdata = rst ? '0 : wdata_raw;
    assign mem_stall  = ~rst & stall;
    assign load_data  = (rst | ~(mem_valid_in & mem_read) | mis) ? '0 : load_fmt;

    assign wait_inc = (wait_cnt == '1) ? wait_cnt : wait_cnt + 32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            data_buf    <= '0;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            if (capture) data_buf <= data_rdata;
            // wait_cnt equals the number of BUSY cycles already completed.
            if (state == BUSY && state_nxt == BUSY) wait_cnt <= wait_inc;
            else                                    wait_cnt <= '0;
            if (MAX_WAIT != 0 && state == BUSY && wait_inc == MAX_WAIT_U) mem_timeout <= 1'b1;
        end
    end

`ifdef MEM_MISALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) misaligned_o <= 1'b0;
        else     misaligned_o <= mis;
    end
`endif

endmodule
